ternary_neuron_acc: RTL and testbench
=====================================

// Module: ternary_neuron_acc
// PURPOSE
//  Serial ternary neuron: accepts N_INPUTS (activation, weight) ternary pairs on a
//  valid/ready stream, accumulates their products, adds a signed bias and emits the
//  7-bit signed pre-activation value that sign_activation consumes.
//  Sits between the layer-0 activation stream and sign_activation; one instance per neuron.
// PARAMETERS
//  N_INPUTS  8   pairs per evaluation; legal range 1..64
//  ACC_W     7   accumulator/output width, signed; fixed at 7 to match sign_activation
//  CNT_W     6   beat counter width; must satisfy 2**CNT_W >= N_INPUTS
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin an evaluation; sampled only in IDLE
//  bias       in   7      signed bias; latched on the accepted start
//  in_valid   in   1      act/wgt pair present
//  in_ready   out  1      high only in ACCUM
//  act        in   2      ternary activation: 01=+1, 11=-1, 00=0, 10=illegal->0
//  wgt        in   2      ternary weight, same encoding
//  out_valid  out  1      result present; high only in DONE
//  out_ready  in   1      downstream accepts the result
//  out_val    out  7      signed result; equals acc register
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, bias_q=0. Outputs in_ready=0, out_valid=0,
//   out_val=0, busy=0. Reset is asynchronous and aborts any evaluation; no partial
//   result is emitted.
//  FSM (registered state; all outputs decode from state or registers, no in->out paths):
//   IDLE : start=1 -> acc<=0, cnt<=0, bias_q<=bias, goto ACCUM.
//   ACCUM: a beat is in_valid & in_ready. Per beat: p=act*wgt in {-1,0,+1},
//          acc<=sat(acc+p), cnt<=cnt+1. The beat with cnt==N_INPUTS-1 -> goto BIAS.
//          in_valid gaps stall without changing acc or cnt.
//   BIAS : one cycle; acc<=sat(acc+bias_q), goto DONE.
//   DONE : out_valid=1. out_val holds stable until out_valid&out_ready -> goto IDLE.
//  start outside IDLE is ignored. A start in the same cycle as the DONE handshake is
//   also ignored, because state is not yet IDLE. bias changes after latch have no effect.
//  Arithmetic: sums are computed at ACC_W+1 bits, then clamped to [-64,+63] on every add.
//   Clamping is per step, so the result is order-dependent once saturated.
//   Illegal code 2'b10 on act or wgt contributes p=0.
//  Latency: with no stalls, out_valid rises one cycle after the edge that accepts the
//   last beat. Throughput is one evaluation per N_INPUTS+3 cycles minimum.
// STRUCTURE
//  Shared package nn_pkg: ternary code constants (TERN_POS=2'b01, TERN_NEG=2'b11,
//   TERN_ZERO=2'b00), state enum {IDLE,ACCUM,BIAS,DONE}, sat7() clamp function.
//  Sub-module ternary_mult: combinational act x wgt -> 2-bit ternary product. It is
//   reused by any future parallel-neuron block.
// TESTING
//  1 N=8, bias=0, 8 beats act=+1,wgt=+1, out_ready=1 -> out_val=8, out_valid high 1 cycle
//    after the last beat.
//  2 Mixed: act={+1,-1,0,+1,-1,-1,+1,10b}, wgt all +1, bias=-3 -> acc 0 before the bias,
//    out_val=-3.
//  3 Saturation: bias=60, 8x(+1*+1) -> out_val=63. bias=-64, 8x(+1*-1) -> out_val=-64.
//  4 Stalls and backpressure: in_valid toggling 1/0 -> same result as test 1.
//    out_ready held low 5 cycles -> out_val and out_valid stable, in_ready=0, start ignored.
//  5 Reset: assert rst_n=0 after 4 beats -> all outputs 0 immediately.
//    Restart with bias=5, 8x(+1*+1) -> out_val=13.
//  6 Back-to-back: start pulses in DONE and IDLE with out_ready=1 -> only the IDLE start is
//    taken. The second result is independent of the first.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-net definitions: ternary code points, neuron FSM states and the
// 7-bit saturating clamp used by the accumulating neurons.
package nn_pkg;

    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp an 8-bit signed sum into the 7-bit signed range [-64, +63].
    function automatic logic signed [6:0] sat7(input logic signed [7:0] s);
        logic signed [6:0] r;
        if (s > 8'sd63)
            r = 7'sd63;
        else if (s < -8'sd64)
            r = -7'sd64;
        else
            r = s[6:0];
        return r;
    endfunction

endpackage

// File: rtl/ternary_mult.sv
// Combinational ternary multiplier: act x wgt -> ternary product code.
// The illegal code 2'b10 is treated as zero on either operand.
module ternary_mult
    import nn_pkg::*;
(
    input  logic [1:0] act,
    input  logic [1:0] wgt,
    output logic [1:0] prod
);

    logic act_nz;
    logic wgt_nz;

    assign act_nz = (act == TERN_POS) || (act == TERN_NEG);
    assign wgt_nz = (wgt == TERN_POS) || (wgt == TERN_NEG);

    always_comb begin
        prod = TERN_ZERO;
        if (act_nz && wgt_nz)
            prod = ((act == TERN_NEG) ^ (wgt == TERN_NEG)) ? TERN_NEG : TERN_POS;
    end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Serial ternary neuron: accumulates N_INPUTS act*wgt products with per-step
// saturation, adds a latched bias and presents the 7-bit pre-activation value.
module ternary_neuron_acc
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 7,
    parameter int CNT_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              act,
    input  logic [1:0]              wgt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_val,
    output logic                    busy
);

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [ACC_W-1:0] bias_q_reg, bias_q_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    logic [1:0]              prod;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   beat_sum;
    logic signed [ACC_W:0]   bias_sum;
    logic                    beat;
    logic                    last_beat;

    ternary_mult u_mult (
        .act  (act),
        .wgt  (wgt),
        .prod (prod)
    );

    always_comb begin
        prod_ext = '0;
        if (prod == TERN_POS)
            prod_ext = {{ACC_W{1'b0}}, 1'b1};
        else if (prod == TERN_NEG)
            prod_ext = '1;
    end

    // Sums are formed one bit wider than the accumulator so overflow is visible to the clamp.
    assign beat_sum  = $signed({acc_reg[ACC_W-1], acc_reg}) + prod_ext;
    assign bias_sum  = $signed({acc_reg[ACC_W-1], acc_reg})
                     + $signed({bias_q_reg[ACC_W-1], bias_q_reg});
    assign beat      = in_valid && (state_reg == ACCUM);
    assign last_beat = (cnt_reg == CNT_W'(N_INPUTS - 1));

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        bias_q_next = bias_q_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next    = '0;
                    cnt_next    = '0;
                    bias_q_next = bias;
                    state_next  = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_next = sat7(beat_sum);
                    cnt_next = cnt_reg + 1'b1;
                    if (last_beat)
                        state_next = BIAS;
                end
            end
            BIAS: begin
                acc_next   = sat7(bias_sum);
                state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            bias_q_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            bias_q_reg <= bias_q_next;
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_val   = acc_reg;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Self-checking bench for ternary_neuron_acc: directed cases plus randomized
// evaluations against an integer reference model with per-step clamping.
module tb_ternary_neuron_acc;
    import nn_pkg::*;

    localparam int N = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic signed [6:0] bias;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        act;
    logic [1:0]        wgt;
    logic              out_valid;
    logic              out_ready;
    logic signed [6:0] out_val;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] act_tab [N];
    logic [1:0] wgt_tab [N];

    ternary_neuron_acc #(.N_INPUTS(N), .ACC_W(7), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        n_cmp++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    function automatic int tern(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic int clamp(input int v);
        if (v > 63) return 63;
        if (v < -64) return -64;
        return v;
    endfunction

    function automatic logic [1:0] rand_code();
        logic [1:0] c;
        c = 2'($urandom_range(0, 3));
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full evaluation from IDLE using act_tab/wgt_tab; expected result from the model.
    task automatic run_eval(input string name, input int b, input bit gaps,
                            input int stall, input bit start_in_done);
        int acc;
        int expv;
        acc = 0;
        for (int i = 0; i < N; i++)
            acc = clamp(acc + tern(act_tab[i]) * tern(wgt_tab[i]));
        expv = clamp(acc + b);

        start = 1'b1;
        bias  = 7'(b);
        tick();
        start = 1'b0;
        bias  = ~bias;
        check_val({name, " busy"}, int'(busy), 1);
        check_val({name, " in_ready"}, int'(in_ready), 1);
        for (int i = 0; i < N; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                act = TERN_POS;
                wgt = TERN_POS;
                tick();
                check_val({name, " gap out_valid"}, int'(out_valid), 0);
            end
            in_valid = 1'b1;
            act = act_tab[i];
            wgt = wgt_tab[i];
            tick();
        end
        in_valid  = 1'b0;
        check_val({name, " bias-cycle out_valid"}, int'(out_valid), 0);
        check_val({name, " bias-cycle in_ready"}, int'(in_ready), 0);
        out_ready = (stall == 0);
        tick();
        check_val({name, " out_valid"}, int'(out_valid), 1);
        check_val({name, " out_val"}, int'(out_val), expv);
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            bias  = 7'($urandom_range(0, 127));
            tick();
            check_val({name, " stall out_valid"}, int'(out_valid), 1);
            check_val({name, " stall out_val"}, int'(out_val), expv);
            check_val({name, " stall in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        start     = start_in_done;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check_val({name, " post out_valid"}, int'(out_valid), 0);
        check_val({name, " post busy"}, int'(busy), 0);
        $display("eval %s bias=%0d expected=%0d", name, b, expv);
    endtask

    task automatic fill_const(input logic [1:0] a, input logic [1:0] w);
        for (int i = 0; i < N; i++) begin
            act_tab[i] = a;
            wgt_tab[i] = w;
        end
    endtask

    initial begin
        logic [1:0] mixed [N];
        rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
        act = '0; wgt = '0; out_ready = 1'b0;
        #12;
        check_val("reset in_ready", int'(in_ready), 0);
        check_val("reset out_valid", int'(out_valid), 0);
        check_val("reset out_val", int'(out_val), 0);
        check_val("reset busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        fill_const(TERN_POS, TERN_POS);
        run_eval("t1 all+1", 0, 1'b0, 0, 1'b0);

        mixed = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10};
        for (int i = 0; i < N; i++) begin
            act_tab[i] = mixed[i];
            wgt_tab[i] = TERN_POS;
        end
        run_eval("t2 mixed", -3, 1'b0, 0, 1'b0);

        fill_const(TERN_POS, TERN_POS);
        run_eval("t3 sat hi", 60, 1'b0, 0, 1'b0);
        fill_const(TERN_POS, TERN_NEG);
        run_eval("t3 sat lo", -64, 1'b0, 0, 1'b0);

        fill_const(TERN_POS, TERN_POS);
        run_eval("t4 stall", 0, 1'b1, 5, 1'b0);

        // Reset mid-evaluation must clear outputs without waiting for a clock.
        start = 1'b1; bias = 7'sd20;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; act = TERN_POS; wgt = TERN_POS;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("t5 rst in_ready", int'(in_ready), 0);
        check_val("t5 rst out_valid", int'(out_valid), 0);
        check_val("t5 rst out_val", int'(out_val), 0);
        check_val("t5 rst busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_eval("t5 restart", 5, 1'b0, 0, 1'b0);

        // Start during the DONE handshake is ignored; the following IDLE start is taken.
        run_eval("t6 first", 7, 1'b0, 0, 1'b1);
        fill_const(TERN_NEG, TERN_POS);
        run_eval("t6 second", -2, 1'b0, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                act_tab[i] = rand_code();
                wgt_tab[i] = rand_code();
            end
            run_eval($sformatf("rand%0d", r), int'($urandom_range(0, 127)) - 64,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
